// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder slice with a registered carry,
// processing WIDTH-bit operands LSB first under a start/busy/done handshake.
module serial_adder #(
  parameter int WIDTH = 8,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  // Full-adder slice built from two half-adder stages plus the carry OR.
  logic ha1_s, ha1_c, ha2_s, ha2_c, fa_c;

  always_comb begin
    ha1_s = opa_q[0] ^ opb_q[0];
    ha1_c = opa_q[0] & opb_q[0];
    ha2_s = ha1_s ^ carry_q;
    ha2_c = ha1_s & carry_q;
    fa_c  = ha1_c | ha2_c;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          opa_d   = a;
          opb_d   = sub ? ~b : b;
          carry_d = sub;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        res_d            = res_q >> 1;
        res_d[WIDTH-1]   = ha2_s;
        opa_d            = opa_q >> 1;
        opb_d            = opb_q >> 1;
        carry_d          = fa_c;
        cnt_d            = cnt_q + CW'(1);
        // On the MSB cycle carry_q is the carry into the MSB, so overflow
        // and the published result are captured here, on entry to FIN.
        if (cnt_q == LAST_BIT) begin
          state_d = ST_FIN;
          sum_d   = res_d;
          cout_d  = fa_c;
          ovf_d   = carry_q ^ fa_c;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_FIN);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised, bit-serial successor to the single-bit adder cell: adds or subtracts two WIDTH-bit operands one bit per clock, LSB first.
- Uses one full-adder slice (two half-adder stages plus carry OR) with a registered carry.
- Has a start/busy/done handshake, so it trades latency for area in datapaths that need wide add/sub only occasionally.
- Operands are captured at start; the result is held until the next start.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..64.
- CW, $clog2(WIDTH+1), bit-counter width; derived, do not override.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start  in  1  request; sampled only in IDLE
- sub  in  1  0 = A+B, 1 = A-B; captured with start
- a  in  WIDTH  operand A; captured with start
- b  in  WIDTH  operand B; captured with start
- busy  out  1  high while bits are being processed
- done  out  1  one-cycle pulse when the result becomes valid
- sum  out  WIDTH  result, modulo 2^WIDTH
- cout  out  1  carry out of MSB; for subtract, 1 = no borrow
- ovf  out  1  two's-complement signed overflow

Behaviour:
- Reset: rst sampled high at a clock edge forces state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, and clears counter, carry and operand registers. Reset has priority over all other inputs, including mid-operation; no partial result is ever exposed.
- States: IDLE, RUN, FIN.
- IDLE:
  - On start=1, capture opA=a, opB = sub ? ~b : b, carry=sub, cnt=0; go to RUN.
  - sum/cout/ovf keep their previous values.
- RUN (busy=1):
  - Each cycle: s = opA[0]^opB[0]^carry; c = (opA[0]&opB[0]) | (carry&(opA[0]^opB[0])).
  - Shift the result register right with s inserted at the MSB; shift opA and opB right by 1; carry<=c; cnt<=cnt+1.
  - On the processing cycle where cnt==WIDTH-1, also record cin_msb = the carry entering that bit. Next state is FIN.
- FIN (busy=0, done=1 for exactly this cycle):
  - sum = result register; cout = carry; ovf = cin_msb ^ carry.
  - Unconditionally return to IDLE next cycle. start is ignored in FIN.
- Outputs sum/cout/ovf update only on entry to FIN. They are stable from the done cycle until the next FIN or reset. During RUN they retain the previous result.
- Latency: start high at edge k -> busy high in cycles k+1..k+WIDTH -> done high in cycle k+WIDTH+1. Throughput is one operation per WIDTH+2 cycles (start accepted again at the edge ending the first IDLE cycle after FIN).
- start, a, b and sub are ignored while busy or in FIN; changing them mid-operation has no effect.
- WIDTH=1: RUN lasts one cycle; ovf = carry-in ^ carry-out of that bit.
- Arithmetic: subtract is A + ~B + 1. cout=0 on subtract means A<B unsigned.

Test Plan:
- WIDTH=8, rst 2 cycles, then start with a=0x05, b=0x03, sub=0 -> busy high 8 cycles, done pulse on the 9th cycle after start, sum=0x08, cout=0, ovf=0.
- a=0xFF, b=0x01, sub=0 -> sum=0x00, cout=1, ovf=0; then a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1.
- sub=1, a=0x05, b=0x07 -> sum=0xFE, cout=0, ovf=0; then sub=1, a=0x80, b=0x01 -> sum=0x7F, cout=1, ovf=1.
- Start a=0x10, b=0x20; pulse start with a=0xAA, b=0x55 and toggle sub on cycles 3 and 5 of RUN -> result sum=0x30, one done pulse only, second request not queued.
- Start an op, assert rst on RUN cycle 4 -> next cycle busy=0, done=0, sum=0, cout=0, ovf=0; a fresh start then completes normally with the correct result.
- Randomised check, 1000 ops at WIDTH=1, 8 and 32 against a reference model of sum/cout/ovf; assert done is a single-cycle pulse and busy is never high together with done.
